// File: rtl/led_display_row_driver_pkg.sv
// led_display_row_driver_pkg: shared row types, widths, driver states and row helpers
package led_display_row_driver_pkg;

    localparam int GL_NUM_COL_PIXELS = 16;
    localparam int GL_ROW_ADDR_W     = 4;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} led_drv_state_t;

    function automatic logic [2:0] half_msb(rgb_half_t h);
        return {h.blue[GL_NUM_COL_PIXELS-1], h.green[GL_NUM_COL_PIXELS-1], h.red[GL_NUM_COL_PIXELS-1]};
    endfunction

    function automatic rgb_half_t half_shl(rgb_half_t h);
        return '{red: h.red << 1, green: h.green << 1, blue: h.blue << 1};
    endfunction

endpackage

// File: rtl/led_display_row_driver_sclk.sv
// led_sclk_strobe_gen: per-column phase timing, fall/rise strobes and last-column flag
module led_sclk_strobe_gen
    import led_display_row_driver_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic last_col
);
    localparam int PW = $clog2(2 * SCLK_DIV);
    localparam int CW = $clog2(GL_NUM_COL_PIXELS);
    logic [PW-1:0] phase;
    logic [CW-1:0] col;
    always_ff @(posedge clk_in) begin
        if (reset_in || !en) begin
            phase <= '0;
            col   <= CW'(GL_NUM_COL_PIXELS - 1);
        end else if (fall) begin
            phase <= '0;
            col   <= last_col ? col : col - 1'b1;
        end else begin
            phase <= phase + 1'b1;
        end
    end
    assign rise     = en && (phase == PW'(SCLK_DIV - 1));
    assign fall     = en && (phase == PW'(2 * SCLK_DIV - 1));
    assign last_col = (col == '0);
endmodule

// File: rtl/led_display_row_driver.sv
// led_display_row_driver: serialises ready/valid RGB rows onto a HUB75-style panel
module led_display_row_driver
    import led_display_row_driver_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int SCLK_DIV       = 4,
    parameter int BLANK_CYCLES   = 4,
    parameter int DISPLAY_CYCLES = 1000,
    parameter int SIMULATION     = 0
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [GL_RGB_ROW_W-1:0]  row_in,
    input  logic                     row_valid_in,
    output logic                     row_ready_out,
    input  logic [GL_ROW_ADDR_W-1:0] row_address_in,
    output logic [2:0]               rgb_top_out,
    output logic [2:0]               rgb_bot_out,
    output logic                     sclk_out,
    output logic                     latch_out,
    output logic                     oe_n_out,
    output logic [GL_ROW_ADDR_W-1:0] addr_out
);
    localparam int MAX_DWELL = (BLANK_CYCLES > DISPLAY_CYCLES) ? BLANK_CYCLES : DISPLAY_CYCLES;
    localparam int DW        = $clog2(MAX_DWELL + 1);

    if (SIMULATION != 0) begin : g_param_check
        if (SCLK_DIV < 1 || BLANK_CYCLES < 1 || DISPLAY_CYCLES < 1 || SYS_CLK_FREQ < 1 || GL_NUM_COL_PIXELS < 2)
            $error("led_display_row_driver: parameter out of range");
    end

    led_drv_state_t           state, next_state;
    logic                     rise, fall, last_col, xfer;
    logic [DW-1:0]            dwell;
    logic [GL_ROW_ADDR_W-1:0] addr_q;
    rgb_half_t                sr_top, sr_bot;
    rgb_row_t                 row;

    assign row  = row_in;
    assign xfer = row_valid_in && row_ready_out;

    led_sclk_strobe_gen #(.SCLK_DIV(SCLK_DIV)) u_strobe (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .en       (state == SHIFT),
        .rise     (rise),
        .fall     (fall),
        .last_col (last_col)
    );

    always_ff @(posedge clk_in) begin
        state <= reset_in ? IDLE : next_state;
        dwell <= (reset_in || state != next_state) ? '0 : (dwell == DW'(MAX_DWELL) ? dwell : dwell + 1'b1);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = xfer ? SHIFT : IDLE;
            SHIFT:   next_state = (fall && last_col) ? BLANK : SHIFT;
            BLANK:   next_state = (dwell == DW'(BLANK_CYCLES - 1)) ? LATCH : BLANK;
            LATCH:   next_state = DISPLAY;
            DISPLAY: next_state = (dwell == DW'(DISPLAY_CYCLES - 1)) ? IDLE : DISPLAY;
            default: next_state = IDLE;
        endcase
    end

    // ready rises one cycle after entering IDLE, giving the full row period between transfers
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            row_ready_out <= 1'b0;
            sclk_out      <= 1'b0;
            latch_out     <= 1'b0;
            oe_n_out      <= 1'b1;
            addr_out      <= '0;
            addr_q        <= '0;
            rgb_top_out   <= '0;
            rgb_bot_out   <= '0;
            sr_top        <= '0;
            sr_bot        <= '0;
        end else begin
            row_ready_out <= (state == IDLE) && !xfer;
            sclk_out      <= (state == SHIFT) && (rise || (sclk_out && !fall));
            latch_out     <= (next_state == LATCH);
            oe_n_out      <= (next_state == BLANK) ? 1'b1 : (next_state == DISPLAY) ? 1'b0 : oe_n_out;
            if (next_state == LATCH)
                addr_out <= addr_q;
            if (xfer) begin
                addr_q      <= row_address_in;
                rgb_top_out <= half_msb(row.top);
                rgb_bot_out <= half_msb(row.bot);
                sr_top      <= half_shl(row.top);
                sr_bot      <= half_shl(row.bot);
            end else if (fall && !last_col) begin
                rgb_top_out <= half_msb(sr_top);
                rgb_bot_out <= half_msb(sr_bot);
                sr_top      <= half_shl(sr_top);
                sr_bot      <= half_shl(sr_bot);
            end
        end
    end
endmodule

// File: tb/tb_led_display_row_driver.sv
// tb_led_display_row_driver: directed vectors for the HUB75 row driver
module tb_led_display_row_driver;
    import led_display_row_driver_pkg::*;

    localparam int N       = GL_NUM_COL_PIXELS;
    localparam int LAT_OFS = 1 + 4 * N + 4;
    localparam int PERIOD  = 4 * N + 23;

    logic                     clk_in = 0;
    logic                     reset_in = 1;
    rgb_row_t                 row_in = '0;
    logic                     row_valid_in = 0;
    logic                     row_ready_out;
    logic [GL_ROW_ADDR_W-1:0] row_address_in = '0;
    logic [2:0]               rgb_top_out, rgb_bot_out;
    logic                     sclk_out, latch_out, oe_n_out;
    logic [GL_ROW_ADDR_W-1:0] addr_out;

    led_display_row_driver #(
        .SCLK_DIV(2), .BLANK_CYCLES(4), .DISPLAY_CYCLES(16), .SIMULATION(1)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .row_in         (row_in),
        .row_valid_in   (row_valid_in),
        .row_ready_out  (row_ready_out),
        .row_address_in (row_address_in),
        .rgb_top_out    (rgb_top_out),
        .rgb_bot_out    (rgb_bot_out),
        .sclk_out       (sclk_out),
        .latch_out      (latch_out),
        .oe_n_out       (oe_n_out),
        .addr_out       (addr_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [N-1:0] seq [6];
    int   mon_rises = 0, mon_latches = 0, mon_viol = 0, mon_oe_run = 0, latch_cyc = 0;
    logic [GL_ROW_ADDR_W-1:0] latch_addr = '0;
    logic armed = 0, prev_sclk = 0;
    logic [5:0] prev_rgb = '0;

    always @(negedge clk_in) begin
        logic [5:0] b;
        b = {rgb_bot_out, rgb_top_out};
        if (sclk_out && latch_out) mon_viol++;
        if (latch_out && !oe_n_out) mon_viol++;
        if (sclk_out && prev_sclk && b != prev_rgb) mon_viol++;
        if (!oe_n_out && !armed) mon_viol++;
        if (sclk_out && !prev_sclk) begin
            mon_rises++;
            for (int i = 0; i < 6; i++) seq[i] = {seq[i][N-2:0], b[i]};
        end
        if (latch_out) begin
            mon_latches++;
            latch_cyc  = cyc;
            latch_addr = addr_out;
        end
        mon_oe_run = oe_n_out ? 0 : mon_oe_run + 1;
        armed      = reset_in ? 1'b0 : latch_out ? 1'b1 : armed;
        prev_sclk  = sclk_out;
        prev_rgb   = b;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input rgb_row_t r, input logic [3:0] a, output int t);
        row_in = r;
        row_address_in = a;
        row_valid_in = 1;
        for (int i = 0; i < 300 && !row_ready_out; i++) tick();
        check("send_ready", row_ready_out, 1);
        t = cyc;
        tick();
        row_valid_in = 0;
    endtask

    task automatic wait_latches(input int base, input int k, input string tag);
        for (int i = 0; i < 400 && mon_latches - base < k; i++) tick();
        check(tag, mon_latches - base, k);
    endtask

    task automatic check_row(input string tag, input rgb_row_t r);
        check({tag, "_tr"}, seq[0], r.top.red);
        check({tag, "_tg"}, seq[1], r.top.green);
        check({tag, "_tb"}, seq[2], r.top.blue);
        check({tag, "_br"}, seq[3], r.bot.red);
        check({tag, "_bg"}, seq[4], r.bot.green);
        check({tag, "_bb"}, seq[5], r.bot.blue);
    endtask

    initial begin
        rgb_row_t pa, pb;
        int t, lb, rb, n;
        int tt [2];
        pa = '0;
        pa.top.red = {N/2{2'b10}};
        pb = '0;
        pb.top.green = 16'hC3A5;
        pb.top.blue  = 16'h8001;
        pb.bot.blue  = 16'h0F0F;
        pb.bot.red   = 16'h1234;

        // reset release
        repeat (3) tick();
        check("rst_ready", row_ready_out, 0);
        check("rst_oe_n", oe_n_out, 1);
        check("rst_addr", addr_out, 0);
        check("rst_latch", latch_out, 0);
        check("rst_sclk", sclk_out, 0);
        check("rst_rgb", {rgb_bot_out, rgb_top_out}, 0);
        reset_in = 0;
        tick();
        check("rel_ready", row_ready_out, 1);

        // alternating red row, address 5
        lb = mon_latches;
        rb = mon_rises;
        send(pa, 4'd5, t);
        wait_latches(lb, 1, "a_latch");
        check("a_latch_time", latch_cyc - t, LAT_OFS);
        check("a_latch_addr", latch_addr, 5);
        check("a_rises", mon_rises - rb, N);
        check_row("a", pa);
        for (int i = 0; i < 200 && !row_ready_out; i++) tick();
        check("a_ready_ret", cyc - t, PERIOD);
        check("a_oe_low_ge16", mon_oe_run >= 16, 1);

        // back-to-back with valid held high
        lb = mon_latches;
        row_in = pa;
        row_address_in = 4'd1;
        row_valid_in = 1;
        n = 0;
        for (int i = 0; i < 400 && n < 2; i++) begin
            if (row_ready_out) begin
                tt[n] = cyc;
                n++;
            end
            tick();
            if (n == 1) begin
                row_in = pb;
                row_address_in = 4'd14;
            end
        end
        row_valid_in = 0;
        check("b2b_count", n, 2);
        check("b2b_gap", tt[1] - tt[0], PERIOD);
        wait_latches(lb, 2, "b2b_latches");
        check("b2b_addr", latch_addr, 14);
        check_row("b2b", pb);

        // valid pulsed mid-SHIFT is ignored
        for (int i = 0; i < 200 && !row_ready_out; i++) tick();
        lb = mon_latches;
        rb = mon_rises;
        send(pb, 4'd9, t);
        repeat (20) tick();
        row_in = pa;
        row_address_in = 4'd3;
        row_valid_in = 1;
        tick();
        row_valid_in = 0;
        wait_latches(lb, 1, "ign_latch");
        check("ign_addr", latch_addr, 9);
        check("ign_rises", mon_rises - rb, N);
        check_row("ign", pb);
        repeat (120) tick();
        check("ign_no_extra", mon_latches - lb, 1);

        // reset in the middle of SHIFT
        lb = mon_latches;
        rb = mon_rises;
        send(pa, 4'd12, t);
        for (int i = 0; i < 200 && mon_rises - rb < N/2; i++) tick();
        check("mid_col", mon_rises - rb, N/2);
        reset_in = 1;
        tick();
        check("mid_rst_ready", row_ready_out, 0);
        check("mid_rst_sclk", sclk_out, 0);
        check("mid_rst_latch", latch_out, 0);
        check("mid_rst_oe_n", oe_n_out, 1);
        check("mid_rst_addr", addr_out, 0);
        check("mid_rst_rgb", {rgb_bot_out, rgb_top_out}, 0);
        reset_in = 0;
        tick();
        check("mid_rel_ready", row_ready_out, 1);
        repeat (100) tick();
        check("mid_no_latch", mon_latches - lb, 0);
        check("mid_oe_n_high", oe_n_out, 1);
        send(pb, 4'd7, t);
        wait_latches(lb, 1, "mid_new_latch");
        check("mid_new_time", latch_cyc - t, LAT_OFS);
        check("mid_new_addr", latch_addr, 7);
        check_row("mid_new", pb);
        repeat (30) tick();

        check("protocol_viol", mon_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
